// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle RV32M-style multiply/divide unit for the execute stage.
// Accepts one MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU at a time over valid/ready.
// The accept cycle performs the first iteration. The result therefore appears
// XLEN/MUL_STEP cycles after accept for multiply and XLEN cycles after accept for
// divide. Divide-by-zero and signed overflow complete in one cycle.
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   flush                       synchronous kill of the held or in-flight op
//   in_valid/in_ready           request handshake (in_ready = IDLE)
//   in_op/in_op1/in_op2/in_tag  request payload, latched at accept
//   out_valid/out_ready         result handshake (out_valid = DONE)
//   out_result/out_tag          result and its pass-through tag
//   busy                        unit not IDLE
module muldiv_unit #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned MUL_STEP = 2,
  parameter int unsigned TAG_W    = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [XLEN-1:0]  in_op1,
  input  logic [XLEN-1:0]  in_op2,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  localparam int unsigned PW    = 2 * XLEN;
  localparam int unsigned MUL_N = XLEN / MUL_STEP;
  localparam int unsigned CNT_W = $clog2(XLEN);

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_REM    = 3'd6;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;

  state_e           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PW-1:0]    acc_q, acc_d, mcand_q, mcand_d;
  logic [XLEN-1:0]  mplier_q, mplier_d, rem_q, rem_d, quo_q, quo_d;
  logic [XLEN-1:0]  dvsr_q, dvsr_d, res_q, res_d;
  logic             negq_q, negq_d, negr_q, negr_d;

  logic             first, op1_s, sdiv, neg1, neg2, div_zero, div_ovf;
  logic             mul_last, div_last, load_mul, load_div, s_negq, s_negr;
  logic [2:0]       s_op;
  logic [CNT_W-1:0] s_cnt;
  logic [PW-1:0]    s_acc, s_mcand, step_acc;
  logic [XLEN-1:0]  s_mplier, s_rem, s_quo, s_dvsr, rem_n, quo_n, mul_res, div_res;
  logic [XLEN:0]    trial;

  // One iteration of either datapath; in IDLE it runs on the freshly prepared operands.
  always_comb begin
    first    = (state_q == S_IDLE);
    op1_s    = (in_op == OP_MULH) || (in_op == OP_MULHSU);
    sdiv     = (in_op == OP_DIV) || (in_op == OP_REM);
    neg1     = sdiv && in_op1[XLEN-1];
    neg2     = sdiv && in_op2[XLEN-1];
    div_zero = (in_op2 == '0);
    div_ovf  = sdiv && (in_op1 == {1'b1, {(XLEN-1){1'b0}}}) && (in_op2 == '1);

    s_op     = first ? in_op : op_q;
    s_cnt    = first ? '0 : cnt_q;
    s_acc    = first ? '0 : acc_q;
    s_mcand  = first ? {{XLEN{op1_s & in_op1[XLEN-1]}}, in_op1} : mcand_q;
    s_mplier = first ? in_op2 : mplier_q;
    s_rem    = first ? '0 : rem_q;
    s_quo    = first ? (neg1 ? -in_op1 : in_op1) : quo_q;
    s_dvsr   = first ? (neg2 ? -in_op2 : in_op2) : dvsr_q;
    s_negq   = first ? (neg1 ^ neg2) : negq_q;
    s_negr   = first ? neg1 : negr_q;

    mul_last = (s_cnt == CNT_W'(MUL_N - 1));
    div_last = (s_cnt == CNT_W'(XLEN - 1));

    // The MSB of a signed multiplier carries negative weight, so it is subtracted.
    step_acc = s_acc;
    for (int j = 0; j < int'(MUL_STEP); j++) begin
      if (s_mplier[j]) begin
        if ((s_op == OP_MULH) && mul_last && (j == int'(MUL_STEP) - 1)) begin
          step_acc = step_acc - (s_mcand << j);
        end else begin
          step_acc = step_acc + (s_mcand << j);
        end
      end
    end
    mul_res = (s_op == OP_MUL) ? step_acc[XLEN-1:0] : step_acc[PW-1:XLEN];

    // Restoring divide on magnitudes: keep the trial difference only if it did not borrow.
    trial   = {s_rem, s_quo[XLEN-1]} - {1'b0, s_dvsr};
    rem_n   = trial[XLEN] ? {s_rem[XLEN-2:0], s_quo[XLEN-1]} : trial[XLEN-1:0];
    quo_n   = {s_quo[XLEN-2:0], ~trial[XLEN]};
    div_res = s_op[1] ? (s_negr ? -rem_n : rem_n) : (s_negq ? -quo_n : quo_n);
  end

  // Next-state and register loads; flush overrides everything and keeps out_result.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    tag_d    = tag_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvsr_d   = dvsr_q;
    res_d    = res_q;
    negq_d   = negq_q;
    negr_d   = negr_q;
    load_mul = 1'b0;
    load_div = 1'b0;

    if (flush) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            op_d   = in_op;
            tag_d  = in_tag;
            negq_d = neg1 ^ neg2;
            negr_d = neg1;
            if (in_op[2] && (div_zero || div_ovf)) begin
              state_d = S_DONE;
              if (div_zero) res_d = in_op[1] ? in_op1 : '1;
              else          res_d = in_op[1] ? '0 : in_op1;
            end else if (in_op[2]) begin
              load_div = 1'b1;
            end else begin
              load_mul = 1'b1;
            end
          end
        end
        S_MUL:   load_mul = 1'b1;
        S_DIV:   load_div = 1'b1;
        S_DONE:  if (out_ready) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase

      if (load_mul) begin
        acc_d    = step_acc;
        mcand_d  = s_mcand << MUL_STEP;
        mplier_d = s_mplier >> MUL_STEP;
        cnt_d    = s_cnt + CNT_W'(1);
        state_d  = mul_last ? S_DONE : S_MUL;
        if (mul_last) res_d = mul_res;
      end
      if (load_div) begin
        rem_d   = rem_n;
        quo_d   = quo_n;
        dvsr_d  = s_dvsr;
        cnt_d   = s_cnt + CNT_W'(1);
        state_d = div_last ? S_DONE : S_DIV;
        if (div_last) res_d = div_res;
      end
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      tag_q    <= '0;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvsr_q   <= '0;
      res_q    <= '0;
      negq_q   <= 1'b0;
      negr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      tag_q    <= tag_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvsr_q   <= dvsr_d;
      res_q    <= res_d;
      negq_q   <= negq_d;
      negr_q   <= negr_d;
    end
  end

  assign in_ready   = (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign out_valid  = (state_q == S_DONE);
  assign out_result = res_q;
  assign out_tag    = tag_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit (XLEN=32, MUL_STEP=2): directed vectors with
// hand-computed results, protocol corner cases, and a short model-checked sweep.
module tb_muldiv_unit;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned MUL_STEP = 2;
  localparam int unsigned TAG_W    = 5;

  logic             clk, rst_n, flush, in_valid, in_ready, out_valid, out_ready, busy;
  logic [2:0]       in_op;
  logic [XLEN-1:0]  in_op1, in_op2, out_result;
  logic [TAG_W-1:0] in_tag, out_tag;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  tag;
    int          lat;
    int          acc;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_err = 0;
  int   cyc   = 0;

  muldiv_unit #(.XLEN(XLEN), .MUL_STEP(MUL_STEP), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_op1(in_op1), .in_op2(in_op2), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_tag(out_tag), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    n_chk++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint p;
    int sa, sbv;
    sa  = a;
    sbv = b;
    p   = 0;
    case (op)
      3'd0: begin p = longint'(a) * longint'(b);    return p[31:0];  end
      3'd1: begin p = longint'(sa) * longint'(sbv); return p[63:32]; end
      3'd2: begin p = longint'(sa) * longint'(b);   return p[63:32]; end
      3'd3: begin p = longint'(a) * longint'(b);    return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFFFFFF;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return a;
        return sa / sbv;
      end
      3'd5: return (b == 0) ? 32'hFFFFFFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
        return sa % sbv;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int model_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (!op[2]) return 16;
    if (b == 0) return 1;
    if (!op[0] && a == 32'h80000000 && b == 32'hFFFFFFFF) return 1;
    return 32;
  endfunction

  // Called at a falling edge: present the request, let it be accepted, then scramble inputs.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] tag, input logic [31:0] res, input int lat, input bit push);
    int   k;
    exp_t e;
    k = 0;
    in_valid = 1'b1; in_op = op; in_op1 = a; in_op2 = b; in_tag = tag;
    while (!in_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready) chk("accept_wait", 64'(in_ready), 64'd1);
    if (push) begin
      e.res = res; e.tag = tag; e.lat = lat; e.acc = cyc;
      exp_q.push_back(e);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_op1   = $urandom;
    in_op2   = $urandom;
    in_tag   = 5'($urandom);
    in_op    = 3'($urandom);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (exp_q.size() != 0) begin
      chk("drain_timeout", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
    end
  endtask

  task automatic run(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [4:0] tag, input logic [31:0] res, input int lat);
    @(negedge clk);
    issue(op, a, b, tag, res, lat, 1'b1);
    drain();
  endtask

  // Monitor: pops the scoreboard on each completed result handshake.
  initial begin
    exp_t e;
    bit   seen;
    int   first_cyc;
    seen = 1'b0;
    first_cyc = 0;
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n) begin
        seen = 1'b0;
      end else begin
        if (out_valid && !seen) begin
          seen = 1'b1;
          first_cyc = cyc;
        end
        if (!out_valid) seen = 1'b0;
        if (out_valid && out_ready && !flush) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_result", 64'(out_result), 64'hDEAD);
          end else begin
            e = exp_q.pop_front();
            chk("result", 64'(out_result), 64'(e.res));
            chk("tag", 64'(out_tag), 64'(e.tag));
            chk("latency", 64'(first_cyc - e.acc), 64'(e.lat));
          end
        end
      end
    end
  end

  initial begin
    logic [2:0]  op;
    logic [31:0] a, b;
    int          k;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_op = '0;
    in_op1 = '0; in_op2 = '0; in_tag = '0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_out_result", 64'(out_result), 64'd0);
    chk("rst_out_tag", 64'(out_tag), 64'd0);
    rst_n = 1'b1;

    // Multiply
    run(3'd0, 32'd7,        32'hFFFFFFFD, 5'd1,  32'hFFFFFFEB, 16);
    run(3'd1, 32'h80000000, 32'h80000000, 5'd2,  32'h40000000, 16);
    run(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3,  32'hFFFFFFFF, 16);
    run(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd4,  32'hFFFFFFFE, 16);
    run(3'd3, 32'h80000000, 32'd2,        5'd5,  32'h00000001, 16);
    run(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd6,  32'h00000000, 16);
    run(3'd0, 32'h0000FFFF, 32'h00010001, 5'd7,  32'hFFFFFFFF, 16);
    // Divide
    run(3'd4, 32'hFFFFFFF9, 32'd2,        5'd8,  32'hFFFFFFFD, 32);
    run(3'd6, 32'hFFFFFFF9, 32'd2,        5'd9,  32'hFFFFFFFF, 32);
    run(3'd5, 32'hFFFFFFFE, 32'd3,        5'd10, 32'h55555554, 32);
    run(3'd7, 32'hFFFFFFFE, 32'd3,        5'd11, 32'h00000002, 32);
    run(3'd4, 32'd7,        32'hFFFFFFFE, 5'd12, 32'hFFFFFFFD, 32);
    run(3'd6, 32'd7,        32'hFFFFFFFE, 5'd13, 32'h00000001, 32);
    run(3'd6, 32'hFFFFFFF8, 32'd3,        5'd14, 32'hFFFFFFFE, 32);
    run(3'd5, 32'h80000000, 32'hFFFFFFFF, 5'd15, 32'h00000000, 32);
    // Special cases
    run(3'd4, 32'd5,        32'd0,        5'd16, 32'hFFFFFFFF, 1);
    run(3'd6, 32'd5,        32'd0,        5'd17, 32'h00000005, 1);
    run(3'd5, 32'd5,        32'd0,        5'd18, 32'hFFFFFFFF, 1);
    run(3'd7, 32'd7,        32'd0,        5'd19, 32'h00000007, 1);
    run(3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd20, 32'h80000000, 1);
    run(3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd21, 32'h00000000, 1);

    // Back-pressure in DONE
    out_ready = 1'b0;
    @(negedge clk);
    issue(3'd5, 32'd100, 32'd7, 5'd9, 32'd14, 32, 1'b1);
    k = 0;
    while (!out_valid && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("bp_valid", 64'(out_valid), 64'd1);
    repeat (10) begin
      chk("bp_result", 64'(out_result), 64'd14);
      chk("bp_tag", 64'(out_tag), 64'd9);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    #1;
    chk("bp_release_idle", 64'(in_ready), 64'd1);
    drain();

    // Reset in the middle of a divide
    @(negedge clk);
    issue(3'd4, 32'h12345678, 32'd3, 5'd2, 32'd0, 0, 1'b0);
    repeat (12) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_result", 64'(out_result), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run(3'd6, 32'hFFFFFFF9, 32'd2, 5'd22, 32'hFFFFFFFF, 32);

    // Flush during a divide, with a competing request
    @(negedge clk);
    issue(3'd4, 32'h00000100, 32'd3, 5'd3, 32'd0, 0, 1'b0);
    repeat (3) @(negedge clk);
    flush = 1'b1; in_valid = 1'b1; in_op = 3'd0; in_op1 = 32'd5; in_op2 = 32'd6; in_tag = 5'd7;
    @(negedge clk);
    chk("flush_div_in_ready", 64'(in_ready), 64'd1);
    chk("flush_div_busy", 64'(busy), 64'd0);
    chk("flush_div_out_valid", 64'(out_valid), 64'd0);
    flush = 1'b0;
    issue(3'd0, 32'd5, 32'd6, 5'd11, 32'd30, 16, 1'b1);
    drain();

    // Flush in DONE, with out_ready and a competing request
    out_ready = 1'b0;
    @(negedge clk);
    issue(3'd4, 32'd5, 32'd0, 5'd12, 32'd0, 0, 1'b0);
    chk("flush_done_valid", 64'(out_valid), 64'd1);
    flush = 1'b1; out_ready = 1'b1; in_valid = 1'b1; in_op = 3'd3;
    @(negedge clk);
    chk("flush_done_out_valid", 64'(out_valid), 64'd0);
    chk("flush_done_in_ready", 64'(in_ready), 64'd1);
    chk("flush_done_busy", 64'(busy), 64'd0);
    flush = 1'b0;
    issue(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd13, 32'hFFFFFFFE, 16, 1'b1);
    drain();

    // Model-checked sweep including zero divisors and overflow operands
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = $urandom;
      if ($urandom_range(0, 7) == 0) b = 32'd0;
      if ($urandom_range(0, 9) == 0) begin
        a = 32'h80000000;
        b = 32'hFFFFFFFF;
      end
      run(op, a, b, 5'(i), model(op, a, b), model_lat(op, a, b));
    end

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule
